// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one RAM port between the instruction-fetch and data load/store
// requesters of CPUS cores. One access is in flight at a time. Cores are
// served round-robin, and inside a core a data request beats an instruction
// request.
//
// Handshake (every requester): a request (iREN, or dREN/dWEN) is held high
// until its wait output reads 0 in the same cycle. In that cycle the access
// is complete and, for reads, the load output carries the RAM data. A request
// with its enable low sees wait = 0. Dropping a request before completion
// abandons it, and nothing is signalled for it.
//
// Ports
//   CLK, nRST          clock; synchronous active-low reset
//   iREN/iaddr         per-core instruction read request and address
//   iwait/iload        per-core instruction wait and read data
//   dREN/dWEN          per-core data read / write request (write wins if both)
//   daddr/dstore       per-core data address and write data
//   dwait/dload        per-core data wait and read data
//   ramREN/ramWEN      RAM read / write enable
//   ramaddr/ramstore   RAM address and write data
//   ramload/ram_ready  RAM read data and completion strobe
//   fsm_state          debug view of the FSM: 0 = IDLE, 1 = ACCESS
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic [CPUS-1:0]             iREN,
    input  logic [CPUS-1:0][WORD_W-1:0] iaddr,
    output logic [CPUS-1:0]             iwait,
    output logic [CPUS-1:0][WORD_W-1:0] iload,
    input  logic [CPUS-1:0]             dREN,
    input  logic [CPUS-1:0]             dWEN,
    input  logic [CPUS-1:0][WORD_W-1:0] daddr,
    input  logic [CPUS-1:0][WORD_W-1:0] dstore,
    output logic [CPUS-1:0]             dwait,
    output logic [CPUS-1:0][WORD_W-1:0] dload,
    output logic                        ramREN,
    output logic                        ramWEN,
    output logic [WORD_W-1:0]           ramaddr,
    output logic [WORD_W-1:0]           ramstore,
    input  logic [WORD_W-1:0]           ramload,
    input  logic                        ram_ready,
    output logic                        fsm_state
);

    // A single core still needs a 1-bit index register.
    localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [GW-1:0]   grant_core, grant_core_next;
    logic [GW-1:0]   last_core, last_core_next;
    logic            grant_is_data, grant_is_data_next;

    logic [CPUS-1:0] req_any;
    logic [CPUS-1:0] gsel;

    logic            pick_found;
    logic [GW-1:0]   pick_core;
    logic            pick_is_data;

    logic            g_iren, g_dren, g_dwen;
    logic [WORD_W-1:0] g_iaddr, g_daddr, g_dstore;
    logic            grant_active;
    logic            complete;

    assign fsm_state = (state == ACCESS);

    // Per-core request summary and one-hot decode of the granted core.
    always_comb begin
        req_any = '0;
        gsel    = '0;
        for (int c = 0; c < CPUS; c++) begin
            req_any[c] = iREN[c] | dREN[c] | dWEN[c];
            gsel[c]    = (grant_core == GW'(c));
        end
    end

    // Round-robin pick: the scan starts one past the last completed core,
    // so the core served most recently is considered last.
    always_comb begin
        pick_found   = 1'b0;
        pick_core    = '0;
        pick_is_data = 1'b0;
        for (int i = 0; i < CPUS; i++) begin
            for (int c = 0; c < CPUS; c++) begin
                if (!pick_found && (c == ((int'(last_core) + 1 + i) % CPUS)) && req_any[c]) begin
                    pick_found   = 1'b1;
                    pick_core    = GW'(c);
                    pick_is_data = dREN[c] | dWEN[c];
                end
            end
        end
    end

    // Signals of the granted requester, selected by the one-hot decode.
    always_comb begin
        g_iren   = 1'b0;
        g_dren   = 1'b0;
        g_dwen   = 1'b0;
        g_iaddr  = '0;
        g_daddr  = '0;
        g_dstore = '0;
        for (int c = 0; c < CPUS; c++) begin
            if (gsel[c]) begin
                g_iren   = iREN[c];
                g_dren   = dREN[c];
                g_dwen   = dWEN[c];
                g_iaddr  = iaddr[c];
                g_daddr  = daddr[c];
                g_dstore = dstore[c];
            end
        end
    end

    // The grant only counts while its own request line is still up; a
    // withdrawn request kills the RAM enables in the same cycle.
    always_comb begin
        grant_active = grant_is_data ? (g_dren | g_dwen) : g_iren;
        complete     = (state == ACCESS) & grant_active & ram_ready;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state         <= IDLE;
            grant_core    <= '0;
            grant_is_data <= 1'b0;
            last_core     <= GW'(CPUS - 1);
        end else begin
            state         <= state_next;
            grant_core    <= grant_core_next;
            grant_is_data <= grant_is_data_next;
            last_core     <= last_core_next;
        end
    end

    always_comb begin
        state_next         = state;
        grant_core_next    = grant_core;
        grant_is_data_next = grant_is_data;
        last_core_next     = last_core;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next         = ACCESS;
                    grant_core_next    = pick_core;
                    grant_is_data_next = pick_is_data;
                end
            end
            ACCESS: begin
                if (!grant_active) begin
                    // Withdrawal wins over a simultaneous ram_ready.
                    state_next = IDLE;
                end else if (ram_ready) begin
                    state_next     = IDLE;
                    last_core_next = grant_core;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // RAM port drive.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if ((state == ACCESS) && grant_active) begin
            if (grant_is_data) begin
                ramWEN   = g_dwen;
                ramREN   = g_dren & ~g_dwen;
                ramaddr  = g_daddr;
                ramstore = g_dstore;
            end else begin
                ramREN  = 1'b1;
                ramaddr = g_iaddr;
            end
        end
    end

    // Requester-side wait and load outputs.
    always_comb begin
        iwait = '0;
        dwait = '0;
        iload = '0;
        dload = '0;
        for (int c = 0; c < CPUS; c++) begin
            iwait[c] = iREN[c] & ~(complete & gsel[c] & ~grant_is_data);
            dwait[c] = (dREN[c] | dWEN[c]) & ~(complete & gsel[c] & grant_is_data);
            if (complete && gsel[c] && !grant_is_data) begin
                iload[c] = ramload;
            end
            if (complete && gsel[c] && grant_is_data) begin
                dload[c] = ramload;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with CPUS = 2. A transaction-level model of
// the arbiter (who holds the grant, who was served last) predicts every RAM
// and requester output and is compared against the DUT on every falling edge.
// Completions seen on the DUT's wait outputs are matched in order against an
// expected queue filled by the directed sequences, and a set of literal
// checks pins the cycle-exact behaviour of each sequence.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int CPUS   = 2;
    localparam int WORD_W = 32;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic [CPUS-1:0]             iREN, dREN, dWEN;
    logic [CPUS-1:0][WORD_W-1:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]             iwait, dwait;
    logic [CPUS-1:0][WORD_W-1:0] iload, dload;
    logic                        ramREN, ramWEN, ram_ready;
    logic [WORD_W-1:0]           ramaddr, ramstore, ramload;
    logic                        fsm_state;

    mem_arbiter #(.CPUS(CPUS), .WORD_W(WORD_W)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dwait     (dwait),
        .dload     (dload),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ram_ready (ram_ready),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    // Expected completion order; tag = 8'h10 * is_data + core.
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Grant held by the model: m_busy says an access is outstanding.
    logic m_busy, n_busy, m_data, n_data;
    int   m_core, n_core, m_last, n_last;

    logic              g_ireq, g_dren, g_dwen, act, done;
    logic [WORD_W-1:0] g_iaddr, g_daddr, g_dstore;
    logic              e_ren, e_wen;
    logic [WORD_W-1:0] e_addr, e_store;
    logic [CPUS-1:0]   e_iwait, e_dwait;
    logic [CPUS-1:0][WORD_W-1:0] e_iload, e_dload;
    logic [7:0]        tag;
    int                cand;

    initial begin
        m_busy = 1'b0; m_data = 1'b0; m_core = 0; m_last = CPUS - 1;
        n_busy = 1'b0; n_data = 1'b0; n_core = 0; n_last = CPUS - 1;
    end

    always @(posedge CLK) begin
        m_busy = n_busy;
        m_data = n_data;
        m_core = n_core;
        m_last = n_last;
    end

    // Compare process: predict outputs for this cycle, compare, then decide
    // what the model holds after the next rising edge.
    always @(negedge CLK) begin
        g_ireq = 1'b0; g_dren = 1'b0; g_dwen = 1'b0;
        g_iaddr = '0; g_daddr = '0; g_dstore = '0;
        for (int c = 0; c < CPUS; c++) begin
            if (c == m_core) begin
                g_ireq = iREN[c]; g_dren = dREN[c]; g_dwen = dWEN[c];
                g_iaddr = iaddr[c]; g_daddr = daddr[c]; g_dstore = dstore[c];
            end
        end
        act     = m_busy && (m_data ? (g_dren || g_dwen) : g_ireq);
        done    = act && ram_ready;
        e_wen   = act && m_data && g_dwen;
        e_ren   = act && (m_data ? (g_dren && !g_dwen) : 1'b1);
        e_addr  = !act ? '0 : (m_data ? g_daddr : g_iaddr);
        e_store = (act && m_data) ? g_dstore : '0;
        for (int c = 0; c < CPUS; c++) begin
            e_iwait[c] = iREN[c] && !(done && !m_data && c == m_core);
            e_dwait[c] = (dREN[c] || dWEN[c]) && !(done && m_data && c == m_core);
            e_iload[c] = (done && !m_data && c == m_core) ? ramload : '0;
            e_dload[c] = (done && m_data && c == m_core) ? ramload : '0;
        end
        chk("ramREN",    64'(ramREN),    64'(e_ren));
        chk("ramWEN",    64'(ramWEN),    64'(e_wen));
        chk("ramaddr",   64'(ramaddr),   64'(e_addr));
        chk("ramstore",  64'(ramstore),  64'(e_store));
        chk("iwait",     64'(iwait),     64'(e_iwait));
        chk("dwait",     64'(dwait),     64'(e_dwait));
        chk("iload",     64'(iload),     64'(e_iload));
        chk("dload",     64'(dload),     64'(e_dload));
        chk("fsm_state", 64'(fsm_state), 64'(m_busy));

        // Completions as the DUT reports them, matched in order.
        for (int c = 0; c < CPUS; c++) begin
            if (iREN[c] && !iwait[c]) begin
                tag = 8'(c);
                if (exp_q.size() == 0) chk("completion_unexpected", 64'(tag), 64'hFF);
                else chk("completion_order", 64'(tag), 64'(exp_q.pop_front()));
            end
            if ((dREN[c] || dWEN[c]) && !dwait[c]) begin
                tag = 8'h10 + 8'(c);
                if (exp_q.size() == 0) chk("completion_unexpected", 64'(tag), 64'hFF);
                else chk("completion_order", 64'(tag), 64'(exp_q.pop_front()));
            end
        end

        // Next model state.
        n_busy = m_busy; n_data = m_data; n_core = m_core; n_last = m_last;
        if (!nRST) begin
            n_busy = 1'b0; n_data = 1'b0; n_core = 0; n_last = CPUS - 1;
        end else if (!m_busy) begin
            for (int k = 0; k < CPUS; k++) begin
                cand = (m_last + 1 + k) % CPUS;
                for (int c = 0; c < CPUS; c++) begin
                    if (!n_busy && c == cand && (iREN[c] || dREN[c] || dWEN[c])) begin
                        n_busy = 1'b1;
                        n_core = c;
                        n_data = dREN[c] || dWEN[c];
                    end
                end
            end
        end else if (!act) begin
            n_busy = 1'b0;
        end else if (ram_ready) begin
            n_busy = 1'b0;
            n_last = m_core;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ram_ready = 1'b0;
    endtask

    task automatic do_reset();
        step(); nRST = 1'b0; clear_inputs(); sample();
        step(); nRST = 1'b1; sample();
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        nRST = 1'b0;
        clear_inputs();

        // Reset state.
        step(); sample();
        chk("rst_ramREN",  64'(ramREN),    64'h0);
        chk("rst_ramWEN",  64'(ramWEN),    64'h0);
        chk("rst_ramaddr", 64'(ramaddr),   64'h0);
        chk("rst_state",   64'(fsm_state), 64'h0);
        chk("rst_iload",   64'(iload),     64'h0);
        step(); sample();

        // Single instruction fetch, ram_ready in the first ACCESS cycle.
        step(); nRST = 1'b1; iREN = 2'b01; iaddr[0] = 32'h0000_0040; sample();
        chk("t1_c1_state", 64'(fsm_state), 64'h0);
        chk("t1_c1_iwait", 64'(iwait),     64'h1);
        step(); ram_ready = 1'b1; ramload = 32'h8C01_0004; exp_q.push_back(8'h00); sample();
        chk("t1_c2_ramREN",  64'(ramREN),   64'h1);
        chk("t1_c2_ramaddr", 64'(ramaddr),  64'h40);
        chk("t1_c2_iwait",   64'(iwait),    64'h0);
        chk("t1_c2_iload0",  64'(iload[0]), 64'h8C01_0004);
        step(); iREN = 2'b00; ram_ready = 1'b0; ramload = '0; sample();
        chk("t1_c3_state", 64'(fsm_state), 64'h0);

        // Data beats instruction on the same core.
        step(); dREN = 2'b01; daddr[0] = 32'h100; iREN = 2'b01; iaddr[0] = 32'h44; sample();
        step(); ram_ready = 1'b1; ramload = 32'h1111_2222; exp_q.push_back(8'h10); sample();
        chk("t2_data_addr",  64'(ramaddr),  64'h100);
        chk("t2_data_iwait", 64'(iwait),    64'h1);
        chk("t2_data_dload", 64'(dload[0]), 64'h1111_2222);
        step(); dREN = 2'b00; ram_ready = 1'b0; sample();
        chk("t2_idle_iwait", 64'(iwait), 64'h1);
        step(); ram_ready = 1'b1; ramload = 32'h3333_4444; exp_q.push_back(8'h00); sample();
        chk("t2_inst_addr",  64'(ramaddr),  64'h44);
        chk("t2_inst_iload", 64'(iload[0]), 64'h3333_4444);
        step(); clear_inputs(); sample();

        // Two cores writing continuously alternate, starting with core 0.
        do_reset();
        step();
        dWEN = 2'b11; daddr[0] = 32'h200; daddr[1] = 32'h300;
        dstore[0] = 32'hAAAA_0000; dstore[1] = 32'hBBBB_0000; ram_ready = 1'b1;
        exp_q.push_back(8'h10); exp_q.push_back(8'h11);
        exp_q.push_back(8'h10); exp_q.push_back(8'h11);
        sample();
        chk("t3_idle_ramWEN", 64'(ramWEN), 64'h0);
        chk("t3_idle_dwait",  64'(dwait),  64'h3);
        for (int k = 1; k <= 7; k++) begin
            step(); sample();
            if (k == 1 || k == 5) begin
                chk("t3_store_core0", 64'(ramstore), 64'hAAAA_0000);
                chk("t3_addr_core0",  64'(ramaddr),  64'h200);
                chk("t3_wen_core0",   64'(ramWEN),   64'h1);
            end
            if (k == 3 || k == 7) begin
                chk("t3_store_core1", 64'(ramstore), 64'hBBBB_0000);
                chk("t3_addr_core1",  64'(ramaddr),  64'h300);
            end
        end
        step(); clear_inputs(); sample();

        // RAM latency of three stalled ACCESS cycles.
        step(); dREN = 2'b01; daddr[0] = 32'h400; sample();
        chk("t4_idle_dwait", 64'(dwait), 64'h1);
        for (int k = 0; k < 3; k++) begin
            step(); sample();
            chk("t4_stall_dwait",   64'(dwait),   64'h1);
            chk("t4_stall_ramaddr", 64'(ramaddr), 64'h400);
            chk("t4_stall_ramREN",  64'(ramREN),  64'h1);
        end
        step(); ram_ready = 1'b1; ramload = 32'h5555_AAAA; exp_q.push_back(8'h10); sample();
        chk("t4_done_dwait", 64'(dwait), 64'h0);
        chk("t4_done_dload", 64'(dload), {32'h0, 32'h5555_AAAA});
        step(); clear_inputs(); sample();

        // Core 1 withdraws in its second ACCESS cycle while ram_ready rises.
        step(); dREN = 2'b10; daddr[1] = 32'h500; sample();
        step(); sample();
        chk("t5_stall_ramaddr", 64'(ramaddr), 64'h500);
        step(); dREN = 2'b00; ram_ready = 1'b1; ramload = 32'hDEAD_BEEF; sample();
        chk("t5_wd_ramREN", 64'(ramREN),    64'h0);
        chk("t5_wd_ramWEN", 64'(ramWEN),    64'h0);
        chk("t5_wd_dwait",  64'(dwait),     64'h0);
        chk("t5_wd_dload",  64'(dload),     64'h0);
        chk("t5_wd_state",  64'(fsm_state), 64'h1);
        step(); ram_ready = 1'b0; dREN = 2'b11; daddr[0] = 32'h600; sample();
        chk("t5_idle_state", 64'(fsm_state), 64'h0);
        step(); ram_ready = 1'b1; ramload = 32'h1234_5678; exp_q.push_back(8'h11); sample();
        chk("t5_core1_first", 64'(ramaddr), 64'h500);
        chk("t5_core1_dload", 64'(dload),   {32'h1234_5678, 32'h0});
        step(); dREN = 2'b01; sample();
        step(); exp_q.push_back(8'h10); sample();
        chk("t5_core0_next", 64'(ramaddr), 64'h600);
        step(); clear_inputs(); sample();

        // Reset during a stalled ACCESS.
        step(); iREN = 2'b10; iaddr[1] = 32'h700; sample();
        step(); sample();
        chk("t6_stall_ramREN", 64'(ramREN), 64'h1);
        step(); nRST = 1'b0; sample();
        step(); nRST = 1'b1; dREN = 2'b01; daddr[0] = 32'h800; sample();
        chk("t6_post_ramREN", 64'(ramREN),    64'h0);
        chk("t6_post_ramWEN", 64'(ramWEN),    64'h0);
        chk("t6_post_state",  64'(fsm_state), 64'h0);
        step(); ram_ready = 1'b1; ramload = 32'hCAFE_F00D; exp_q.push_back(8'h10); sample();
        chk("t6_core0_first", 64'(ramaddr), 64'h800);
        step(); dREN = 2'b00; ram_ready = 1'b0; sample();
        step(); ram_ready = 1'b1; ramload = 32'h0BAD_C0DE; exp_q.push_back(8'h01); sample();
        chk("t6_core1_addr",  64'(ramaddr), 64'h700);
        chk("t6_core1_iload", 64'(iload),   {32'h0BAD_C0DE, 32'h0});
        step(); clear_inputs(); sample();
        step(); sample();

        chk("completions_left", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
